// File: rtl/csr_stage_pkg.sv
// Shared definitions for the Zicsr sequencer: funct3 encodings and FSM states.
package csr_stage_pkg;

  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CALC = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/csr_stage_alu.sv
// Combinational read-modify-write core: new CSR value, write decision and
// illegal-op detection from the latched op, the old value and the operand.
module csr_alu
  import csr_stage_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic [2:0]          op,
  input  logic [WORD_LEN-1:0] old_val,
  input  logic [WORD_LEN-1:0] operand,
  input  logic                suppress,
  output logic [WORD_LEN-1:0] new_val,
  output logic                do_write,
  output logic                illegal
);

  // Select the update rule; set/clear forms honour the suppress flag.
  always_comb begin
    new_val  = old_val;
    do_write = 1'b0;
    illegal  = 1'b0;
    case (op)
      CSR_OP_RW, CSR_OP_RWI: begin
        new_val  = operand;
        do_write = 1'b1;
      end
      CSR_OP_RS, CSR_OP_RSI: begin
        new_val  = old_val | operand;
        do_write = ~suppress;
      end
      CSR_OP_RC, CSR_OP_RCI: begin
        new_val  = old_val & ~operand;
        do_write = ~suppress;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_stage.sv
// Zicsr sequencer between execute and the CSR register file.
// Accept -> READ (address to file) -> CALC (write, capture result) -> RESP.
// Optional macro CSR_STAGE_RO_CHECK_EN: block writes to read-only CSRs
// (addr[11:10] == 2'b11) and flag them illegal.
module csr_stage
  import csr_stage_pkg::*;
#(
  parameter int WORD_LEN      = 32,
  parameter int REG_ADDR_SIZE = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [REG_ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_LEN-1:0]      req_rs1,
  input  logic [4:0]               req_uimm,
  input  logic                     req_rs1_is_x0,
  output logic                     resp_valid,
  output logic [WORD_LEN-1:0]      resp_rdata,
  output logic                     resp_illegal,
  output logic [REG_ADDR_SIZE-1:0] csr_addr,
  input  logic [WORD_LEN-1:0]      csr_rdata,
  output logic                     csr_wen,
  output logic [WORD_LEN-1:0]      csr_wdata
);

  state_t                   state, state_nxt;
  logic                     accept;
  logic [2:0]               op_p0;
  logic [REG_ADDR_SIZE-1:0] addr_p0;
  logic                     sup_p0;
  logic [WORD_LEN-1:0]      operand_p0;
  logic [WORD_LEN-1:0]      alu_new;
  logic                     alu_wr;
  logic                     alu_ill;
  logic                     ro_blk;
  logic                     wr_ok;
  logic                     bad;

  assign req_ready = (state == IDLE) || (state == RESP);
  assign accept    = req_valid && req_ready;
  assign csr_addr  = addr_p0;

  csr_alu #(.WORD_LEN(WORD_LEN)) u_alu (
    .op       (op_p0),
    .old_val  (csr_rdata),
    .operand  (operand_p0),
    .suppress (sup_p0),
    .new_val  (alu_new),
    .do_write (alu_wr),
    .illegal  (alu_ill)
  );

`ifdef CSR_STAGE_RO_CHECK_EN
  assign ro_blk = (addr_p0[REG_ADDR_SIZE-1 -: 2] == 2'b11) && alu_wr;
`else
  assign ro_blk = 1'b0;
`endif

  assign wr_ok = alu_wr && !ro_blk;
  assign bad   = alu_ill || ro_blk;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // --- stage p0: latch request control fields on accept ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0   <= 3'b000;
      addr_p0 <= '0;
      sup_p0  <= 1'b0;
    end else if (accept) begin
      op_p0   <= req_op;
      addr_p0 <= req_addr;
      sup_p0  <= req_op[2] ? (req_uimm == 5'd0) : req_rs1_is_x0;
    end
  end

  // Latch the operand (zero-extended zimm for immediate forms) on accept.
  always_ff @(posedge clk) begin
    if (accept)
      operand_p0 <= req_op[2] ? {{(WORD_LEN-5){1'b0}}, req_uimm} : req_rs1;
  end

  // --- response stage: capture old value / illegal flag at the end of CALC ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata   <= '0;
      resp_illegal <= 1'b0;
    end else if (state == CALC) begin
      resp_rdata   <= bad ? '0 : csr_rdata;
      resp_illegal <= bad;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    csr_wen    = 1'b0;
    csr_wdata  = '0;
    resp_valid = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = READ;
      READ: state_nxt = CALC;
      CALC: begin
        csr_wen   = wr_ok;
        csr_wdata = alu_new;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = accept ? READ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_stage.sv
// Randomized self-checking bench for csr_stage with a behavioural CSR file
// and a reference model of Zicsr semantics.
module tb_csr_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [11:0] req_addr = 12'h000;
  logic [31:0] req_rs1 = 32'h0;
  logic [4:0]  req_uimm = 5'h0;
  logic        req_rs1_is_x0 = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [31:0] csr_wdata;

  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'h0;
  logic [31:0] pl_data = 32'h0;

  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  csr_stage dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_rs1(req_rs1), .req_uimm(req_uimm),
    .req_rs1_is_x0(req_rs1_is_x0),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_wen(csr_wen), .csr_wdata(csr_wdata)
  );

  // CSR register file: registered read, write port sharing the address.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (csr_wen) mem[csr_addr] <= csr_wdata;
    csr_rdata <= mem[csr_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the stage is idle; returns at a negedge.
  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
    @(negedge clk);
  endtask

  // Architectural Zicsr result for one instruction against ref_mem.
  task automatic model(input logic [2:0] op, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] uimm, input logic x0,
                       output logic ill, output logic wr, output logic [31:0] newv,
                       output logic [31:0] rdata);
    logic [31:0] old, src;
    old  = ref_mem[a];
    src  = op[2] ? 32'(uimm) : rs1;
    ill  = 1'b0; wr = 1'b0; newv = old;
    case (op[1:0])
      2'd1: begin newv = src; wr = 1'b1; end
      2'd2: begin newv = old | src;  wr = op[2] ? (uimm != 0) : !x0; end
      2'd3: begin newv = old & ~src; wr = op[2] ? (uimm != 0) : !x0; end
      default: ill = 1'b1;
    endcase
`ifdef CSR_STAGE_RO_CHECK_EN
    if (a[11:10] == 2'b11 && wr) begin ill = 1'b1; wr = 1'b0; end
`endif
    rdata = ill ? 32'h0 : old;
  endtask

  // Present a request at the current negedge (IDLE or RESP), follow it to RESP.
  task automatic run_req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] rs1,
                         input logic [4:0] uimm, input logic x0);
    logic ill, wr;
    logic [31:0] newv, rdata;
    logic [2:0] vmask, wmask;
    model(op, a, rs1, uimm, x0, ill, wr, newv, rdata);
    req_valid = 1'b1; req_op = op; req_addr = a; req_rs1 = rs1;
    req_uimm = uimm; req_rs1_is_x0 = x0;
    chk("ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs while busy: the stage must use its latched copy.
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = 12'($urandom);
    req_rs1 = $urandom; req_uimm = 5'($urandom); req_rs1_is_x0 = 1'($urandom);
    vmask = 3'b000; wmask = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vmask[k] = resp_valid;
      wmask[k] = csr_wen;
      if (k == 1 && wr) begin
        chk("wdata", csr_wdata, newv);
        chk("waddr", 32'(csr_addr), 32'(a));
      end
    end
    chk("vld_lat", 32'(vmask), 32'd4);
    chk("wen_lat", 32'(wmask), wr ? 32'd2 : 32'd0);
    chk("rdata", resp_rdata, rdata);
    chk("illegal", 32'(resp_illegal), 32'(ill));
    if (wr) ref_mem[a] = newv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_vld", 32'(resp_valid), 32'd0);
      chk("idle_wen", 32'(csr_wen), 32'd0);
    end
  endtask

  logic [11:0] addrs [8];

  initial begin
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h340; addrs[3] = 12'h341;
    addrs[4] = 12'hC00; addrs[5] = 12'hC01; addrs[6] = 12'h7C0; addrs[7] = 12'hB00;

    // Reset values.
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_vld", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_ill", 32'(resp_illegal), 32'd0);
    chk("rst_addr", 32'(csr_addr), 32'd0);
    chk("rst_wen", 32'(csr_wen), 32'd0);
    chk("rst_wdata", csr_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) preload(addrs[i], $urandom);

    // Directed cases.
    preload(12'h305, 32'h0000_1000);
    run_req(3'b001, 12'h305, 32'h8000_0000, 5'd0, 1'b0);
    idle(1);
    preload(12'h300, 32'h0000_0008);
    run_req(3'b110, 12'h300, 32'h0, 5'd3, 1'b0);
    run_req(3'b011, 12'h300, 32'h2, 5'd0, 1'b0);
    chk("rc_result", ref_mem[12'h300], 32'h0000_0009);
    idle(2);
    run_req(3'b010, 12'h340, 32'hFFFF_FFFF, 5'd0, 1'b1);
    idle(1);
    run_req(3'b100, 12'h300, 32'h1234_5678, 5'd7, 1'b0);
    idle(1);
    run_req(3'b000, 12'h341, 32'h1, 5'd1, 1'b0);
    idle(1);
    run_req(3'b001, 12'h341, 32'h55, 5'd0, 1'b0);
    run_req(3'b010, 12'h341, 32'h100, 5'd0, 1'b0);
    idle(1);
    run_req(3'b010, 12'h341, 32'h0, 5'd0, 1'b1);
    chk("b2b_val", resp_rdata, 32'h0000_0155);
    idle(1);

    // Reset asserted during CALC: write dropped, no response.
    req_valid = 1'b1; req_op = 3'b001; req_addr = 12'h305;
    req_rs1 = 32'hDEAD_BEEF; req_uimm = 5'd0; req_rs1_is_x0 = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("calc_wen", 32'(csr_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_wen", 32'(csr_wen), 32'd0);
    chk("mrst_vld", 32'(resp_valid), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("mrst_rdata", resp_rdata, 32'd0);
    run_req(3'b110, 12'h305, 32'h0, 5'd0, 1'b0);

    // Read-only region (illegal writes only when the check is enabled).
    idle(1);
    run_req(3'b001, 12'hC00, 32'h1111_2222, 5'd0, 1'b0);
    run_req(3'b010, 12'hC00, 32'h0, 5'd0, 1'b1);
    run_req(3'b111, 12'hC01, 32'h0, 5'd0, 1'b0);
    idle(1);

    // Randomized traffic, mixing back-to-back and gapped requests.
    for (int n = 0; n < 80; n++) begin
      logic [4:0] u;
      u = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_req(3'($urandom), addrs[$urandom_range(0, 7)], $urandom, u,
              1'($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
